// File: rtl/aud_recorder.sv
// I2S-style ADC capture: deserialises one channel per LRC rise and emits
// one SRAM write strobe per completed sample, with pause/resume/stop control.
module aud_recorder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_recording
);

  localparam int unsigned       CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(DATA_W);
  localparam logic [ADDR_W-1:0] LAST     = '1;

  typedef enum logic [2:0] {IDLE, WAIT, RECV, STORE, PAUSE} state_t;

  state_t            state;
  logic              lrc_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [ADDR_W-1:0] addr;
  logic              lrc_rise;

  assign lrc_rise = i_lrc && !lrc_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      lrc_q       <= 1'b0;
      bit_cnt     <= CNT_INIT;
      shreg       <= '0;
      addr        <= '0;
      o_data      <= '0;
      o_address   <= '0;
      o_valid     <= 1'b0;
      o_full      <= 1'b0;
      o_recording <= 1'b0;
    end else begin
      lrc_q   <= i_lrc;
      o_valid <= 1'b0;
      // Stop outranks everything, including a word sitting in STORE.
      if (i_stop) begin
        state       <= IDLE;
        o_recording <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (i_start && !i_pause) begin
              state       <= WAIT;
              addr        <= '0;
              o_full      <= 1'b0;
              o_recording <= 1'b1;
            end
          end
          WAIT: begin
            if (i_pause) begin
              state       <= PAUSE;
              o_recording <= 1'b0;
            end else if (lrc_rise) begin
              state   <= RECV;
              bit_cnt <= CNT_INIT;
            end
          end
          RECV: begin
            shreg   <= {shreg[DATA_W-2:0], i_data};
            bit_cnt <= bit_cnt - 1'b1;
            // Leaving on the last bit makes STORE land at E+DATA_W+1.
            if (bit_cnt == CNT_W'(1)) begin
              state       <= STORE;
              o_recording <= 1'b0;
            end
          end
          STORE: begin
            o_data    <= shreg;
            o_address <= addr;
            o_valid   <= 1'b1;
            if (addr == LAST) begin
              o_full <= 1'b1;
              state  <= IDLE;
            end else begin
              addr <= addr + 1'b1;
              if (i_pause) begin
                state <= PAUSE;
              end else begin
                state       <= WAIT;
                o_recording <= 1'b1;
              end
            end
          end
          PAUSE: begin
            if (i_start && !i_pause) begin
              state       <= WAIT;
              o_recording <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aud_recorder.sv
// Scoreboard bench for aud_recorder: a default-width instance for the control
// scenarios and an ADDR_W=3 instance for the full-memory boundary.
module tb_aud_recorder;

  logic        clk = 1'b0;
  logic        rst_n, lrc, sdata, start, pause, stop;
  logic        rst3_n, start3, pause3, stop3;
  logic [15:0] o_data, o_data3;
  logic [19:0] o_address;
  logic [2:0]  o_address3;
  logic        o_valid, o_full, o_recording;
  logic        o_valid3, o_full3, o_recording3;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  int unsigned n_valid  = 0;
  int unsigned n_valid3 = 0;
  int unsigned cyc      = 0;
  int unsigned last_e   = 0;

  logic [35:0] q20[$];
  logic [18:0] q3[$];

  aud_recorder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(sdata),
    .i_start(start), .i_pause(pause), .i_stop(stop),
    .o_data(o_data), .o_address(o_address), .o_valid(o_valid),
    .o_full(o_full), .o_recording(o_recording)
  );

  aud_recorder #(.DATA_W(16), .ADDR_W(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst3_n), .i_lrc(lrc), .i_data(sdata),
    .i_start(start3), .i_pause(pause3), .i_stop(stop3),
    .o_data(o_data3), .o_address(o_address3), .o_valid(o_valid3),
    .o_full(o_full3), .o_recording(o_recording3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitors: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (o_valid) begin
      logic [35:0] e;
      n_valid++;
      if (q20.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        e = q20.pop_front();
        check("data", 64'(o_data), 64'(e[15:0]));
        check("addr", 64'(o_address), 64'(e[35:16]));
        check("latency", 64'(cyc - last_e), 17);
      end
    end
    if (o_valid3) begin
      logic [18:0] e3;
      n_valid3++;
      if (q3.size() == 0) check("unexpected_valid3", 1, 0);
      else begin
        e3 = q3.pop_front();
        check("data3", 64'(o_data3), 64'(e3[15:0]));
        check("addr3", 64'(o_address3), 64'(e3[18:16]));
      end
    end
  end

  // kind: 0 none, 1 raise pause, 2 pulse stop, 3 pulse reset, at bit index 'at'
  task automatic send_word(input logic [15:0] w, input int kind = 0, input int at = 0);
    @(negedge clk);
    lrc    = 1'b1;
    last_e = cyc + 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      sdata = w[15-i];
      if (i == at + 1 && kind == 2) begin
        check("stop_rec_low", 64'(o_recording), 0);
        stop = 1'b0;
      end
      if (i == at + 1 && kind == 3) rst_n = 1'b1;
      if (i == at) begin
        case (kind)
          1: pause = 1'b1;
          2: stop  = 1'b1;
          3: begin
            rst_n = 1'b0;
            #1;
            check("rst_data", 64'(o_data), 0);
            check("rst_addr", 64'(o_address), 0);
            check("rst_valid", 64'(o_valid), 0);
            check("rst_full", 64'(o_full), 0);
            check("rst_rec", 64'(o_recording), 0);
          end
          default: ;
        endcase
      end
    end
    @(negedge clk);
    lrc   = 1'b0;
    sdata = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic new_session();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("session_rec", 64'(o_recording), 1);
  endtask

  initial begin
    int unsigned v0;
    rst_n = 1'b0; rst3_n = 1'b0; lrc = 1'b0; sdata = 1'b0;
    start = 1'b0; pause = 1'b0; stop = 1'b0;
    start3 = 1'b0; pause3 = 1'b0; stop3 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", 64'(o_data), 0);
    check("reset_valid", 64'(o_valid), 0);
    check("reset_rec", 64'(o_recording), 0);
    rst_n = 1'b1; rst3_n = 1'b1;

    // Idle after reset: a word with no start is ignored.
    send_word(16'h1111);
    check("idle_rec", 64'(o_recording), 0);

    // First capture and following address.
    new_session();
    q20.push_back({20'd0, 16'hA5C3}); send_word(16'hA5C3);
    q20.push_back({20'd1, 16'h3C5A}); send_word(16'h3C5A);

    // Three boundary-pattern words.
    new_session();
    v0 = n_valid;
    q20.push_back({20'd0, 16'h0001}); send_word(16'h0001);
    q20.push_back({20'd1, 16'h8000}); send_word(16'h8000);
    q20.push_back({20'd2, 16'hFFFF}); send_word(16'hFFFF);
    check("three_pulses", 64'(n_valid - v0), 3);

    // Pause mid-word: word still stored, capture halts, resume at 2.
    new_session();
    q20.push_back({20'd0, 16'h1234}); send_word(16'h1234);
    q20.push_back({20'd1, 16'hBEEF}); send_word(16'hBEEF, 1, 5);
    check("paused_rec", 64'(o_recording), 0);
    send_word(16'h7777);
    pause = 1'b0;
    send_word(16'h6666);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("resume_rec", 64'(o_recording), 1);
    q20.push_back({20'd2, 16'hCAFE}); send_word(16'hCAFE);

    // Stop mid-word: discarded, address held, restart from 0.
    send_word(16'h5555, 2, 8);
    check("stop_addr_hold", 64'(o_address), 2);
    check("stop_data_hold", 64'(o_data), 64'h0000_CAFE);
    new_session();
    q20.push_back({20'd0, 16'h0F0F}); send_word(16'h0F0F);

    // Pause straight from WAIT.
    @(negedge clk); pause = 1'b1;
    @(negedge clk); pause = 1'b0;
    check("wait_pause_rec", 64'(o_recording), 0);
    send_word(16'h4444);

    // Reset mid-RECV, then simultaneous requests.
    new_session();
    send_word(16'h9999, 3, 8);
    send_word(16'h2222);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("pre_prio_rec", 64'(o_recording), 1);
    @(negedge clk); start = 1'b1; pause = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; pause = 1'b0; stop = 1'b0;
    check("prio_rec", 64'(o_recording), 0);
    send_word(16'h3333);
    check("prio_full", 64'(o_full), 0);

    // Small memory fills after eight words; the ninth is dropped.
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      logic [15:0] w;
      w = 16'h1000 + 16'(i * 16'h0111);
      if (i < 8) q3.push_back({3'(i), w});
      send_word(w);
      if (i == 6) check("not_full_yet", 64'(o_full3), 0);
    end
    check("full3", 64'(o_full3), 1);
    check("full3_rec", 64'(o_recording3), 0);
    check("full3_count", 64'(n_valid3), 8);

    repeat (4) @(negedge clk);
    check("q20_empty", 64'(q20.size()), 0);
    check("q3_empty", 64'(q3.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/aud_recorder.md
AUD_RECORDER -- requirements
Module: aud_recorder

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the sample width in bits.
REQ-002 Parameter ADDR_W, default 20, SHALL set the SRAM word-address width; the last address is 2^ADDR_W-1.
REQ-003 i_clk  input  1  SHALL be the codec bit clock (AUD_BCLK); all logic is on its rising edge.
REQ-004 i_rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 i_lrc  input  1  SHALL be the codec ADC left/right clock (AUD_ADCLRCK).
REQ-006 i_data  input  1  SHALL be the codec serial ADC data (AUD_ADCDAT), MSB first.
REQ-007 i_start  input  1  SHALL be a level request to record or resume.
REQ-008 i_pause  input  1  SHALL be a level request to pause at the next word boundary.
REQ-009 i_stop  input  1  SHALL be a level request to abort immediately.
REQ-010 o_data  output  DATA_W  SHALL be the last completed sample.
REQ-011 o_address  output  ADDR_W  SHALL be the SRAM address for o_data.
REQ-012 o_valid  output  1  SHALL be a one-cycle write strobe for o_data/o_address.
REQ-013 o_full  output  1  SHALL flag that the last address was written.
REQ-014 o_recording  output  1  SHALL be high in states WAIT and RECV.

Function
REQ-015 The block SHALL use states IDLE, WAIT, RECV, STORE and PAUSE.
REQ-016 The block SHALL register i_lrc every cycle as lrc_q.
- Edge cycle E: the rising edge where lrc_q=0 and i_lrc=1.
REQ-017 IDLE: i_start=1 SHALL go to WAIT, clear the address counter to 0 and clear o_full; otherwise stay.
REQ-018 WAIT: at cycle E the block SHALL go to RECV with the bit counter loaded to DATA_W.
- Cycle E itself is the I2S one-bit delay; no data is sampled there.
REQ-019 RECV: at each of cycles E+1..E+DATA_W the block SHALL shift i_data into the shift register (MSB first) and decrement the bit counter.
REQ-020 At counter 0 the block SHALL go to STORE; the word is complete after cycle E+DATA_W.
REQ-021 STORE (one cycle, E+DATA_W+1):
- o_data <= shift register; o_address <= address counter; o_valid pulses at the following edge.
- o_valid SHALL be high for exactly one cycle per stored word.
REQ-022 After STORE, address counter < 2^ADDR_W-1: increment; go to PAUSE if i_pause=1 (sampled in STORE), else WAIT.
REQ-023 After STORE, address counter = 2^ADDR_W-1: set o_full=1, go to IDLE, no wrap-around; o_full holds until the next start from IDLE or reset.
REQ-024 i_pause asserted during WAIT SHALL go to PAUSE at once; during RECV it SHALL be deferred to STORE, so no partial word is lost.
REQ-025 PAUSE: i_start=1 SHALL go to WAIT with the address counter retained.
REQ-026 i_stop=1 in any state SHALL go to IDLE next cycle.
- A partial word is discarded: no o_valid.
- o_data and o_address hold their last values.
REQ-027 Priority on simultaneous requests SHALL be stop > pause > start.
REQ-028 An i_lrc rise during RECV or STORE SHALL be ignored; capture restarts only from WAIT.
REQ-029 In RECV the block SHALL ignore i_start.

Reset
REQ-030 On i_rst_n=0 all of the following SHALL clear asynchronously, in any state including mid-word:
- state=IDLE, lrc_q=0, bit counter=DATA_W, shift register=0.
- o_data=0, o_address=0, o_valid=0, o_full=0, o_recording=0.
REQ-031 After reset release, the block SHALL take no action until i_start=1.

Verification
REQ-032 The bench SHALL cover these scenarios:
- Start, then LRC rise, serial 16'hA5C3 -> o_valid one cycle at E+17, o_data=16'hA5C3, o_address=0; next word at address 1.
- Three words 16'h0001, 16'h8000, 16'hFFFF -> addresses 0,1,2 with matching data; exactly three o_valid pulses.
- i_pause raised at bit 5 of word 2 -> word 2 still stored; no o_valid while paused; i_start resumes at address 2.
- i_stop at bit 8 -> IDLE next cycle, no o_valid, o_address unchanged; a new start restarts at address 0.
- ADDR_W=3, record 9 words -> 8 stored at addresses 0..7, o_full=1, IDLE, 9th word ignored.
- i_rst_n low mid-RECV -> all outputs 0 immediately; i_start, i_pause, i_stop high together -> stop wins, IDLE.
